// File: rtl/hls_ap_ctrl_pkg.sv
// Shared types and constants for the HLS ap_ctrl_hs / ap_ctrl_chain initiator.
package hls_ap_ctrl_pkg;

   localparam int DEF_CNT_W = 32;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } drv_state_e;

   // Start-to-done latency. The subtraction wraps, so a counter that rolled over
   // between start and done still gives the right answer once the caller
   // truncates the result to its counter width (counters up to 64 bits).
   function automatic logic [63:0] lat_sub(input logic [63:0] now, input logic [63:0] ts);
      return now - ts;
   endfunction

endpackage

// File: rtl/hls_ts_fifo.sv
// Start-timestamp FIFO for hls_ap_ctrl_driver. DEPTH x W, show-ahead head.
// A push and a pop in the same cycle while empty is a bypass: the pushed word
// appears on o_head in that cycle and the FIFO contents are left untouched.
module hls_ts_fifo
   import hls_ap_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = DEF_CNT_W,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_din,
   output logic [W-1:0]  o_head,
   output logic          o_empty,
   output logic          o_full,
   output logic          o_bypass,
   output logic [AW:0]   o_count
);

   localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == FULL_CNT);
   assign o_bypass  = i_push && i_pop && o_empty;
   assign w_do_push = i_push && !o_bypass && (!o_full || i_pop);
   assign w_do_pop  = i_pop && !o_bypass && !o_empty;
   assign o_head    = o_empty ? i_din : r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Pointer and occupancy bookkeeping; i_clr empties the FIFO for a new run.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      end
   end

   // Timestamp storage.
   // NOTE: storage array is not reset; occupancy is tracked by r_count, so stale words are never read.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/hls_ap_ctrl_driver.sv
// Block-level initiator for the HLS ap_ctrl_hs / ap_ctrl_chain handshake.
// Issues a programmed number of starts, keeps up to DEPTH in flight, and
// measures start-to-done latency per transaction.
// Optional: define HLS_AP_CTRL_DRV_STALL_EN to add cfg_stall, which holds
// ap_continue low for cfg_stall cycles after every completion.
module hls_ap_ctrl_driver
   import hls_ap_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int DEPTH = DEF_DEPTH
)(
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic [CNT_W-1:0] cfg_num_txn,
`ifdef HLS_AP_CTRL_DRV_STALL_EN
   input  logic [7:0]       cfg_stall,
`endif
   input  logic             cmd_go,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             finished,
   output logic [CNT_W-1:0] txn_started,
   output logic [CNT_W-1:0] txn_done,
   output logic [CNT_W-1:0] lat_last,
   output logic [CNT_W-1:0] lat_max,
   output logic             err_spurious
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   drv_state_e       r_state;
   drv_state_e       w_state_nxt;
   logic             r_ap_start;
   logic             w_ap_start_nxt;
   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_num;
   logic [CNT_W-1:0] r_started;
   logic [CNT_W-1:0] r_done_cnt;
   logic [CNT_W-1:0] r_lat_last;
   logic [CNT_W-1:0] r_lat_max;
   logic             r_err;

   logic             w_idle_or_done;
   logic             w_active;
   logic             w_go;
   logic             w_accept;
   logic             w_handshake;
   logic             w_complete;
   logic             w_spurious;
   logic [CNT_W-1:0] w_started_nxt;
   logic [CNT_W-1:0] w_head;
   logic [CNT_W-1:0] w_lat;
   logic [AW:0]      w_count;
   logic [AW:0]      w_out_nxt;
   logic             w_fifo_empty;
   logic             w_bypass;
   logic             w_unused_full;

   assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
   assign w_active       = (r_state == RUN) || (r_state == DRAIN);
   assign w_go           = cmd_go && w_idle_or_done;
   assign w_accept       = r_ap_start && ap_ready;
   assign w_handshake    = ap_done && ap_continue && w_active;
   // A done only counts if there is a timestamp for it, possibly the one being pushed now.
   assign w_complete     = w_handshake && (!w_fifo_empty || w_accept);
   assign w_spurious     = w_handshake && w_fifo_empty && !w_accept;
   assign w_started_nxt  = r_started + CNT_W'(w_accept);
   assign w_out_nxt      = w_count + (AW+1)'(w_accept) - (AW+1)'(w_complete);
   assign w_lat          = CNT_W'(lat_sub(64'(r_cycle), 64'(w_head)));

   hls_ts_fifo #(
      .DEPTH (DEPTH),
      .W     (CNT_W)
   ) u_ts_fifo (
      .clk      (ap_clk),
      .rst_n    (ap_rst_n),
      .i_clr    (w_go),
      .i_push   (w_accept),
      .i_pop    (w_complete),
      .i_din    (r_cycle),
      .o_head   (w_head),
      .o_empty  (w_fifo_empty),
      .o_full   (w_unused_full),
      .o_bypass (w_bypass),
      .o_count  (w_count)
   );

   // FIFO-full is already implied by the outstanding-count guard on ap_start,
   // and a bypass needs no special handling because o_head then carries the
   // current cycle, so both are intentionally left unused here.
   logic w_unused;
   assign w_unused = w_unused_full ^ w_bypass;

   // Free-running cycle counter, wraps modulo 2^CNT_W.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_cycle <= '0;
      else           r_cycle <= r_cycle + 1'b1;
   end

   // Next state and next ap_start.
   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      w_state_nxt    = r_state;
      w_ap_start_nxt = 1'b0;
      case (r_state)
         IDLE, DONE: if (cmd_go) w_state_nxt = (cfg_num_txn == '0) ? DONE : RUN;
         RUN:        if (w_started_nxt == r_num) w_state_nxt = DRAIN;
         DRAIN:      if (w_count == '0) w_state_nxt = DONE;
         default:    w_state_nxt = IDLE;
      endcase
      if (w_go) begin
         // Counters and FIFO are being cleared, so only the count matters.
         w_ap_start_nxt = (cfg_num_txn != '0);
      end else begin
         w_ap_start_nxt = (w_state_nxt == RUN) && (w_started_nxt < r_num) &&
                          (w_out_nxt < FULL_CNT);
      end
   end

   // State register and registered ap_start; reset drops ap_start immediately.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state    <= IDLE;
         r_ap_start <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ap_start <= w_ap_start_nxt;
      end
   end

   // Transaction counters, latency statistics and the sticky spurious-done flag.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_num      <= '0;
         r_started  <= '0;
         r_done_cnt <= '0;
         r_lat_last <= '0;
         r_lat_max  <= '0;
         r_err      <= 1'b0;
      end else if (w_go) begin
         r_num      <= cfg_num_txn;
         r_started  <= '0;
         r_done_cnt <= '0;
         r_lat_last <= '0;
         r_lat_max  <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept) r_started <= w_started_nxt;
         if (w_complete) begin
            r_done_cnt <= r_done_cnt + 1'b1;
            r_lat_last <= w_lat;
            if (w_lat > r_lat_max) r_lat_max <= w_lat;
         end
         if (w_spurious) r_err <= 1'b1;
      end
   end

`ifdef HLS_AP_CTRL_DRV_STALL_EN
   logic [7:0] r_stall_cfg;
   logic [7:0] r_stall_cnt;

   // Post-completion backpressure countdown; ap_continue stays low while non-zero.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_stall_cfg <= '0;
         r_stall_cnt <= '0;
      end else if (w_go) begin
         r_stall_cfg <= cfg_stall;
         r_stall_cnt <= '0;
      end else if (w_complete) begin
         r_stall_cnt <= r_stall_cfg;
      end else if (r_stall_cnt != '0) begin
         r_stall_cnt <= r_stall_cnt - 1'b1;
      end
   end

   assign ap_continue = (r_state != IDLE) && (r_stall_cnt == '0);
`else
   assign ap_continue = (r_state != IDLE);
`endif

   assign ap_start     = r_ap_start;
   assign busy         = w_active;
   assign finished     = (r_state == DONE);
   assign txn_started  = r_started;
   assign txn_done     = r_done_cnt;
   assign lat_last     = r_lat_last;
   assign lat_max      = r_lat_max;
   assign err_spurious = r_err;

endmodule

// File: tb/tb_hls_ap_ctrl_driver.sv
// Directed bench for hls_ap_ctrl_driver. Two instances (DEPTH 4 and DEPTH 2)
// share the kernel-side inputs; sel_b picks which one the kernel model talks to.
// Cycle k of a test is the clock period after the k-th falling edge following go;
// inputs are driven and outputs sampled on falling edges.
module tb_hls_ap_ctrl_driver;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] cfg_num;
   logic         go_a, go_b, ap_ready, ap_done, sel_b;
`ifdef HLS_AP_CTRL_DRV_STALL_EN
   logic [7:0]   cfg_stall;
`endif

   logic         a_start, a_cont, a_busy, a_fin, a_err;
   logic [W-1:0] a_ts, a_td, a_ll, a_lm;
   logic         b_start, b_cont, b_busy, b_fin, b_err;
   logic [W-1:0] b_ts, b_td, b_ll, b_lm;

   logic         m_start, m_cont, m_busy, m_fin, m_err;
   logic [W-1:0] m_ts, m_td, m_ll, m_lm;

   assign m_start = sel_b ? b_start : a_start;
   assign m_cont  = sel_b ? b_cont  : a_cont;
   assign m_busy  = sel_b ? b_busy  : a_busy;
   assign m_fin   = sel_b ? b_fin   : a_fin;
   assign m_err   = sel_b ? b_err   : a_err;
   assign m_ts    = sel_b ? b_ts    : a_ts;
   assign m_td    = sel_b ? b_td    : a_td;
   assign m_ll    = sel_b ? b_ll    : a_ll;
   assign m_lm    = sel_b ? b_lm    : a_lm;

   hls_ap_ctrl_driver #(.CNT_W(W), .DEPTH(4)) dut_a (
      .ap_clk       (clk),
      .ap_rst_n     (rst_n),
      .cfg_num_txn  (cfg_num),
`ifdef HLS_AP_CTRL_DRV_STALL_EN
      .cfg_stall    (cfg_stall),
`endif
      .cmd_go       (go_a),
      .ap_start     (a_start),
      .ap_ready     (ap_ready),
      .ap_done      (ap_done),
      .ap_continue  (a_cont),
      .busy         (a_busy),
      .finished     (a_fin),
      .txn_started  (a_ts),
      .txn_done     (a_td),
      .lat_last     (a_ll),
      .lat_max      (a_lm),
      .err_spurious (a_err)
   );

   hls_ap_ctrl_driver #(.CNT_W(W), .DEPTH(2)) dut_b (
      .ap_clk       (clk),
      .ap_rst_n     (rst_n),
      .cfg_num_txn  (cfg_num),
`ifdef HLS_AP_CTRL_DRV_STALL_EN
      .cfg_stall    (cfg_stall),
`endif
      .cmd_go       (go_b),
      .ap_start     (b_start),
      .ap_ready     (ap_ready),
      .ap_done      (ap_done),
      .ap_continue  (b_cont),
      .busy         (b_busy),
      .finished     (b_fin),
      .txn_started  (b_ts),
      .txn_done     (b_td),
      .lat_last     (b_ll),
      .lat_max      (b_lm),
      .err_spurious (b_err)
   );

   int total = 0;
   int bad   = 0;

   // Kernel model observations.
   int           m_first, m_last, m_cnt, m_maxout, m_viol;
   logic [127:0] m_cont_hist;
   int           m_comp[$];

   task automatic do_go(input logic use_b, input logic [W-1:0] n);
      @(negedge clk);
      sel_b    = use_b;
      cfg_num  = n;
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      if (use_b) go_b = 1'b1;
      else       go_a = 1'b1;
   endtask

   task automatic step(input logic rdy, input logic dn);
      @(negedge clk);
      go_a     = 1'b0;
      go_b     = 1'b0;
      ap_ready = rdy;
      ap_done  = dn;
   endtask

   // Kernel: always ready; raises ap_done lat cycles after each accept and holds
   // it until ap_continue is seen high. Stops once finished is observed.
   task automatic run_model(input int lat, input int depth, input int budget);
      int due[$];
      int outst;
      outst       = 0;
      m_first     = -1;
      m_last      = -1;
      m_cnt       = 0;
      m_maxout    = 0;
      m_viol      = 0;
      m_cont_hist = '0;
      m_comp.delete();
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         go_a = 1'b0;
         go_b = 1'b0;
         if (m_fin) break;
         ap_ready = 1'b1;
         ap_done  = (due.size() > 0) && (due[0] <= k);
         if (k < 128) m_cont_hist[k] = m_cont;
         if (m_start) begin
            if (m_first < 0) m_first = k;
            m_last = k;
            m_cnt++;
            if (outst >= depth) m_viol++;
         end
         if (ap_done && m_cont) begin
            void'(due.pop_front());
            m_comp.push_back(k);
            outst--;
         end
         if (m_start && ap_ready) begin
            due.push_back(k + lat);
            outst++;
         end
         if (outst > m_maxout) m_maxout = outst;
      end
      ap_ready = 1'b0;
      ap_done  = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({a_start, a_cont, a_busy, a_fin, a_err, a_ts, a_td, a_ll, a_lm} !== '0) begin
         bad++;
         $display("FAIL reset_a_outputs: got start=%b cont=%b busy=%b fin=%b err=%b ts=%0d td=%0d required all 0",
                  a_start, a_cont, a_busy, a_fin, a_err, a_ts, a_td);
      end
      total++;
      if ({b_start, b_cont, b_busy, b_fin, b_err, b_ts, b_td, b_ll, b_lm} !== '0) begin
         bad++;
         $display("FAIL reset_b_outputs: got start=%b cont=%b busy=%b fin=%b required all 0",
                  b_start, b_cont, b_busy, b_fin);
      end
      rst_n = 1'b1;
      step(1'b0, 1'b0);
      total++;
      if (a_cont !== 1'b0 || a_start !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got cont=%b start=%b required 0 0", a_cont, a_start);
      end
   endtask

   task automatic test_basic();
      do_go(1'b0, 32'd3);
      run_model(10, 4, 200);
      total++;
      if (m_fin !== 1'b1) begin bad++; $display("FAIL basic_finished: got %b required 1", m_fin); end
      total++;
      if (m_first != 1 || m_last != 3 || m_cnt != 3) begin
         bad++;
         $display("FAIL basic_start_window: got first=%0d last=%0d cnt=%0d required 1 3 3", m_first, m_last, m_cnt);
      end
      total++;
      if (m_td !== 32'd3 || m_ts !== 32'd3) begin
         bad++; $display("FAIL basic_counts: got started=%0d done=%0d required 3 3", m_ts, m_td);
      end
      total++;
      if (m_ll !== 32'd10 || m_lm !== 32'd10) begin
         bad++; $display("FAIL basic_latency: got last=%0d max=%0d required 10 10", m_ll, m_lm);
      end
      total++;
      if (m_err !== 1'b0 || m_busy !== 1'b0) begin
         bad++; $display("FAIL basic_flags: got err=%b busy=%b required 0 0", m_err, m_busy);
      end
      total++;
      if (m_maxout != 3) begin bad++; $display("FAIL basic_outstanding: got %0d required 3", m_maxout); end
   endtask

   task automatic test_depth_limit();
      do_go(1'b1, 32'd6);
      run_model(20, 2, 300);
      total++;
      if (m_fin !== 1'b1) begin bad++; $display("FAIL depth_finished: got %b required 1", m_fin); end
      total++;
      if (m_maxout != 2 || m_viol != 0) begin
         bad++; $display("FAIL depth_outstanding: got max=%0d starts_while_full=%0d required 2 0", m_maxout, m_viol);
      end
      total++;
      if (m_ts !== 32'd6 || m_td !== 32'd6 || m_cnt != 6) begin
         bad++; $display("FAIL depth_counts: got started=%0d done=%0d start_cycles=%0d required 6 6 6", m_ts, m_td, m_cnt);
      end
      total++;
      if (m_lm !== 32'd20 || m_ll !== 32'd20) begin
         bad++; $display("FAIL depth_latency: got last=%0d max=%0d required 20 20", m_ll, m_lm);
      end
      total++;
      if (m_comp.size() != 6 || m_comp[5] != 64) begin
         bad++; $display("FAIL depth_last_done_cycle: got n=%0d required 6 completions ending at 64", m_comp.size());
      end
   endtask

   task automatic test_ready_delay_and_spurious();
      int hold;
      hold = 0;
      do_go(1'b0, 32'd2);
      for (int k = 1; k <= 5; k++) begin
         step(k == 5, 1'b0);
         if (m_start) hold++;
      end
      total++;
      if (hold != 5 || m_ts !== 32'd0) begin
         bad++; $display("FAIL ready_hold: got high_cycles=%0d started=%0d required 5 0", hold, m_ts);
      end
      step(1'b0, 1'b0);                          // cycle 6
      total++;
      if (m_ts !== 32'd1 || m_start !== 1'b1) begin
         bad++; $display("FAIL ready_accept: got started=%0d start=%b required 1 1", m_ts, m_start);
      end
      step(1'b0, 1'b0);                          // cycle 7
      step(1'b0, 1'b1);                          // cycle 8: done for the cycle-5 accept
      step(1'b1, 1'b1);                          // cycle 9: accept and done, FIFO empty
      total++;
      if (m_ll !== 32'd3 || m_td !== 32'd1) begin
         bad++; $display("FAIL ready_latency: got last=%0d done=%0d required 3 1", m_ll, m_td);
      end
      step(1'b0, 1'b1);                          // cycle 10: DRAIN, nothing outstanding
      total++;
      if (m_ll !== 32'd0 || m_lm !== 32'd3 || m_td !== 32'd2 || m_ts !== 32'd2) begin
         bad++; $display("FAIL bypass_latency: got last=%0d max=%0d done=%0d started=%0d required 0 3 2 2",
                         m_ll, m_lm, m_td, m_ts);
      end
      total++;
      if (m_busy !== 1'b1 || m_start !== 1'b0 || m_err !== 1'b0) begin
         bad++; $display("FAIL drain_state: got busy=%b start=%b err=%b required 1 0 0", m_busy, m_start, m_err);
      end
      step(1'b0, 1'b0);                          // cycle 11
      total++;
      if (m_err !== 1'b1 || m_td !== 32'd2 || m_ll !== 32'd0) begin
         bad++; $display("FAIL spurious_done: got err=%b done=%0d last=%0d required 1 2 0", m_err, m_td, m_ll);
      end
      total++;
      if (m_fin !== 1'b1) begin bad++; $display("FAIL spurious_finished: got %b required 1", m_fin); end
   endtask

   task automatic test_zero_txn();
      int starts;
      do_go(1'b0, 32'd0);
      step(1'b0, 1'b0);                          // cycle 1
      total++;
      if (m_fin !== 1'b1 || m_busy !== 1'b0 || m_err !== 1'b0 || m_ts !== 32'd0) begin
         bad++; $display("FAIL zero_finish: got fin=%b busy=%b err=%b started=%0d required 1 0 0 0",
                         m_fin, m_busy, m_err, m_ts);
      end
      starts = (m_start === 1'b1) ? 1 : 0;
      repeat (4) begin
         step(1'b1, 1'b0);
         if (m_start === 1'b1) starts++;
      end
      total++;
      if (starts != 0) begin bad++; $display("FAIL zero_no_start: got %0d start cycles required 0", starts); end
   endtask

`ifdef HLS_AP_CTRL_DRV_STALL_EN
   task automatic test_stall();
      cfg_stall = 8'd3;
      do_go(1'b0, 32'd2);
      run_model(4, 4, 100);
      cfg_stall = 8'd0;
      total++;
      if (m_fin !== 1'b1 || m_td !== 32'd2) begin
         bad++; $display("FAIL stall_done: got fin=%b done=%0d required 1 2", m_fin, m_td);
      end
      total++;
      if (m_cont_hist[9:5] !== 5'b10001) begin
         bad++; $display("FAIL stall_continue: got cycles9..5=%b required 10001", m_cont_hist[9:5]);
      end
      total++;
      if (m_comp.size() != 2 || m_comp[0] != 5 || m_comp[1] != 9) begin
         bad++; $display("FAIL stall_completion_cycles: got n=%0d required completions at 5 and 9", m_comp.size());
      end
      total++;
      if (m_ll !== 32'd7 || m_lm !== 32'd7) begin
         bad++; $display("FAIL stall_latency: got last=%0d max=%0d required 7 7", m_ll, m_lm);
      end
   endtask
`endif

   task automatic test_reset_mid_run();
      do_go(1'b0, 32'd5);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);                          // cycle 3
      total++;
      if (m_ts !== 32'd2 || m_start !== 1'b1 || m_busy !== 1'b1) begin
         bad++; $display("FAIL midrun_progress: got started=%0d start=%b busy=%b required 2 1 1", m_ts, m_start, m_busy);
      end
      ap_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (a_start !== 1'b0) begin bad++; $display("FAIL async_start_drop: got %b required 0", a_start); end
      total++;
      if ({a_cont, a_busy, a_fin, a_err, a_ts, a_td, a_ll, a_lm} !== '0) begin
         bad++; $display("FAIL async_reset_outputs: got cont=%b busy=%b ts=%0d td=%0d required all 0",
                         a_cont, a_busy, a_ts, a_td);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0);
      total++;
      if (a_fin !== 1'b0 || a_busy !== 1'b0 || a_cont !== 1'b0) begin
         bad++; $display("FAIL post_reset_idle: got fin=%b busy=%b cont=%b required 0 0 0", a_fin, a_busy, a_cont);
      end
   endtask

   initial begin
      cfg_num  = '0;
      go_a     = 1'b0;
      go_b     = 1'b0;
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      sel_b    = 1'b0;
`ifdef HLS_AP_CTRL_DRV_STALL_EN
      cfg_stall = 8'd0;
`endif
      test_reset();
      test_basic();
      test_depth_limit();
      test_ready_delay_and_spurious();
      test_zero_txn();
`ifdef HLS_AP_CTRL_DRV_STALL_EN
      test_stall();
`endif
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hls_ap_ctrl_driver.md
Name: hls_ap_ctrl_driver

Overview:
- Synthesizable initiator for the HLS ap_ctrl_hs / ap_ctrl_chain block-level handshake. It is the driving end of the start/ready/done/continue protocol that the dataflow status monitors observe.
- Issues a programmed number of kernel transactions to one HLS top (e.g. crc24a) and keeps up to DEPTH transactions in flight.
- Timestamps every accepted start and measures start-to-done latency per transaction.
- Sits between the test/control wrapper and the kernel's block-level ports.

Parameters:
- CNT_W, 32: width of the cycle counter, transaction counts and latency values.
- DEPTH, 4: maximum outstanding transactions; also the depth of the timestamp FIFO. Must be a power of 2 and at least 1.

Ports:
- ap_clk, in, 1: clock.
- ap_rst_n, in, 1: asynchronous active-low reset.
- cfg_num_txn, in, CNT_W: transactions to issue; sampled on go.
- cmd_go, in, 1: one-cycle start command.
- ap_start, out, 1: kernel start.
- ap_ready, in, 1: kernel accepted start.
- ap_done, in, 1: kernel transaction complete.
- ap_continue, out, 1: output-consumed acknowledge.
- busy, out, 1: high in RUN or DRAIN.
- finished, out, 1: high in DONE.
- txn_started, out, CNT_W: accepted starts.
- txn_done, out, CNT_W: completed transactions.
- lat_last, out, CNT_W: latency of the most recent completion.
- lat_max, out, CNT_W: maximum latency observed.
- err_spurious, out, 1: sticky flag, ap_done seen with nothing outstanding.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, FIFO empty, cycle counter 0.
  - ap_continue = 0.
  - Reset asserted mid-run aborts immediately; ap_start drops asynchronously.
- Cycle counter increments every cycle from reset and wraps modulo 2^CNT_W.
- FSM IDLE, RUN, DRAIN, DONE:
  - IDLE/DONE + cmd_go: latch cfg_num_txn, clear all counters, lat_*, err_spurious and FIFO. Go to RUN, or to DONE if cfg_num_txn == 0 (finished rises the next cycle).
  - RUN -> DRAIN when txn_started reaches num.
  - DRAIN -> DONE when outstanding == 0.
  - cmd_go in RUN or DRAIN is ignored.
- ap_start:
  - Registered. First assertion is the cycle after go.
  - Next value is high iff next state is RUN, started_next < num and outstanding_next < DEPTH.
  - Held high until accepted; accept = ap_start && ap_ready in the same cycle.
  - Back-to-back accepts are allowed on consecutive cycles.
- On accept: push the current cycle count into the FIFO; txn_started+1; outstanding+1.
- Completion:
  - Completion = ap_done && ap_continue, sampled in RUN or DRAIN.
  - Pop the FIFO head; lat_last = (cycle - ts) mod 2^CNT_W; lat_max = max(lat_max, lat_last); txn_done+1; outstanding-1.
- Accept and completion in the same cycle: outstanding is unchanged.
  - If the FIFO was empty, latency is 0 (the pushed timestamp is bypassed).
- Completion with FIFO empty and no simultaneous accept: ignored and err_spurious is set. Latency and counters are unchanged.
- ap_continue = 1 in RUN, DRAIN and DONE; 0 in IDLE.
- Latency is valid only below 2^CNT_W cycles; no overflow detection.

Optional Feature:
- Macro: HLS_AP_CTRL_DRV_STALL_EN.
- When defined:
  - Adds input cfg_stall (8 bits), sampled on go.
  - After each completion, ap_continue is driven 0 for cfg_stall cycles. The kernel holds ap_done high until ap_continue returns, which exercises ap_ctrl_chain backpressure.
  - A stall countdown register is added.
  - cfg_stall == 0 behaves as if the macro were undefined.
- When undefined: no cfg_stall port, and ap_continue follows the base rule.

Decomposition:
- Package hls_ap_ctrl_pkg holds:
  - the state enum drv_state_e (IDLE, RUN, DRAIN, DONE);
  - the default CNT_W and DEPTH constants;
  - the latency subtraction function.
- Sub-module hls_ts_fifo: DEPTH x CNT_W synchronous FIFO with push, pop, head, empty, full and a same-cycle bypass output.

Test Plan:
- Reset, then go with num=3, DEPTH=4, kernel ap_ready tied 1, ap_done fixed 10 cycles after each accept -> ap_start high for cycles 1-3; txn_done=3; lat_last=lat_max=10; finished high; err_spurious=0.
- num=6, DEPTH=2, ap_done 20 cycles after accept -> at most 2 outstanding; ap_start low while 2 are in flight; txn_started=6; lat_max=20.
- num=0 -> finished the cycle after go; ap_start never asserted.
- ap_ready delayed 5 cycles -> ap_start held 5 cycles and latency measured from the accept cycle; ap_done on the same cycle as an accept with FIFO empty -> lat_last=0.
- ap_done pulse in DRAIN with outstanding 0 -> err_spurious=1 and txn_done unchanged; ap_rst_n low mid-RUN -> all outputs 0 with no clock edge.
- With HLS_AP_CTRL_DRV_STALL_EN and cfg_stall=3, num=2 -> ap_continue low for 3 cycles after the first completion; second done counted only after ap_continue returns high; txn_done=2.
